bp_cfg_io_responder: RTL and testbench

BP_CFG_IO_RESPONDER -- requirements
Module: bp_cfg_io_responder

---
 rtl/bp_cfg_io_pkg.sv | 51 +++++
 rtl/bp_cfg_io_responder.sv | 155 +++++++++++++++
 tb/tb_bp_cfg_io_responder.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_cfg_io_pkg.sv
// Shared definitions for the configuration I/O responder: message layout,
// configuration register map, instruction RAM window and responder FSM states.
package bp_cfg_io_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int cce_io_addr_width_gp    = 40;
  localparam int cce_io_data_width_gp    = 64;
  localparam int num_cce_instr_ram_els_p = 256;
  localparam int cce_inst_width_gp       = 48;

  // Core id width is the only processor-config dependent width used here.
  function automatic int core_id_width(bp_params_e cfg);
    return (cfg == e_bp_default_cfg) ? 4 : 8;
  endfunction

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3,
    e_cce_mem_pre   = 4'd4
  } bp_cce_mem_msg_type_e;

  typedef struct packed {
    bp_cce_mem_msg_type_e             msg_type;
    logic [cce_io_addr_width_gp-1:0]  addr;
    logic [2:0]                       size;
  } bp_cce_io_hdr_s;

  typedef struct packed {
    bp_cce_io_hdr_s                   header;
    logic [cce_io_data_width_gp-1:0]  data;
  } bp_cce_io_msg_s;

  // Offsets within addr[15:0]
  localparam logic [15:0] cfg_reg_freeze_gp     = 16'h0000;
  localparam logic [15:0] cfg_reg_core_id_gp    = 16'h0008;
  localparam logic [15:0] cfg_reg_cce_mode_gp   = 16'h0010;
  localparam logic [15:0] cfg_reg_cache_mode_gp = 16'h0018;
  localparam logic [15:0] cfg_ram_base_gp       = 16'h8000;

  typedef enum logic [1:0] {
    e_ready    = 2'd0,
    e_ram_read = 2'd1,
    e_resp     = 2'd2
  } cfg_io_state_e;

endpackage

// File: rtl/bp_cfg_io_responder.sv
// Configuration I/O responder: services uncached reads/writes of the core
// configuration registers and the CCE instruction RAM, one command at a time.
//
// state      | meaning
// e_ready    | idle, accepts the next command
// e_ram_read | waiting one cycle for instruction RAM read data
// e_resp     | response held valid until the consumer takes it
module bp_cfg_io_responder
  import bp_cfg_io_pkg::*;
#(
  parameter bp_params_e bp_params_p    = e_bp_default_cfg,
  parameter int         inst_ram_els_p = num_cce_instr_ram_els_p,
  parameter int         inst_width_p   = cce_inst_width_gp,
  localparam int core_id_width_p        = core_id_width(bp_params_p),
  localparam int cce_io_msg_width_lp    = $bits(bp_cce_io_msg_s),
  localparam int inst_ram_addr_width_lp = $clog2(inst_ram_els_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,

  input  logic [cce_io_msg_width_lp-1:0]    io_cmd_i,
  input  logic                              io_cmd_v_i,
  output logic                              io_cmd_yumi_o,

  output logic [cce_io_msg_width_lp-1:0]    io_resp_o,
  output logic                              io_resp_v_o,
  input  logic                              io_resp_ready_i,

  output logic                              cfg_freeze_o,
  output logic [core_id_width_p-1:0]        cfg_core_id_o,
  output logic                              cfg_cce_mode_o,
  output logic                              cfg_cache_mode_o,

  output logic                              inst_ram_w_v_o,
  output logic                              inst_ram_r_v_o,
  output logic [inst_ram_addr_width_lp-1:0] inst_ram_addr_o,
  output logic [inst_width_p-1:0]           inst_ram_data_o,
  input  logic [inst_width_p-1:0]           inst_ram_data_i
);

  localparam logic [12:0] ram_els_lp = 13'(inst_ram_els_p);

  bp_cce_io_msg_s cmd;
  bp_cce_io_msg_s resp_r;
  cfg_io_state_e  state_r;

  logic                            cfg_freeze_r;
  logic [core_id_width_p-1:0]      cfg_core_id_r;
  logic                            cfg_cce_mode_r;
  logic                            cfg_cache_mode_r;

  logic [15:0]                     off;
  logic [11:0]                     ram_idx;
  logic                            ram_hit;
  logic                            reg_hit;
  logic                            is_uc_rd;
  logic                            is_uc_wr;
  logic                            accept;
  logic                            reg_wr;
  logic [cce_io_data_width_gp-1:0] reg_rdata;
  logic [cce_io_data_width_gp-1:0] ram_rdata_ext;
  logic                            unused_data_bits;

  assign cmd      = io_cmd_i;
  assign off      = cmd.header.addr[15:0];
  assign ram_idx  = off[14:3];
  // RAM window: 8-byte aligned entries, index must fall inside the RAM
  assign ram_hit  = off[15] & (off[2:0] == 3'b000) & ({1'b0, ram_idx} < ram_els_lp);
  assign is_uc_rd = (cmd.header.msg_type == e_cce_mem_uc_rd);
  assign is_uc_wr = (cmd.header.msg_type == e_cce_mem_uc_wr);

  // Gated by reset so strobes and yumi drop the moment reset asserts
  assign accept   = io_cmd_v_i & reset_i & (state_r == e_ready);
  assign reg_wr   = accept & is_uc_wr & reg_hit;

  assign io_cmd_yumi_o   = accept;
  assign inst_ram_w_v_o  = accept & is_uc_wr & ram_hit;
  assign inst_ram_r_v_o  = accept & is_uc_rd & ram_hit;
  assign inst_ram_addr_o = ram_idx[inst_ram_addr_width_lp-1:0];
  assign inst_ram_data_o = cmd.data[inst_width_p-1:0];

  assign io_resp_o   = resp_r;
  assign io_resp_v_o = (state_r == e_resp);

  assign cfg_freeze_o     = cfg_freeze_r;
  assign cfg_core_id_o    = cfg_core_id_r;
  assign cfg_cce_mode_o   = cfg_cce_mode_r;
  assign cfg_cache_mode_o = cfg_cache_mode_r;

  assign unused_data_bits = ^cmd.data[cce_io_data_width_gp-1:inst_width_p];

  // Register map decode and zero-extended read value
  always_comb begin
    reg_hit   = 1'b1;
    reg_rdata = '0;
    case (off)
      cfg_reg_freeze_gp:     reg_rdata[0] = cfg_freeze_r;
      cfg_reg_core_id_gp:    reg_rdata[core_id_width_p-1:0] = cfg_core_id_r;
      cfg_reg_cce_mode_gp:   reg_rdata[0] = cfg_cce_mode_r;
      cfg_reg_cache_mode_gp: reg_rdata[0] = cfg_cache_mode_r;
      default:               reg_hit = 1'b0;
    endcase
  end

  // Zero-extend instruction RAM read data to the message data width
  always_comb begin
    ram_rdata_ext = '0;
    ram_rdata_ext[inst_width_p-1:0] = inst_ram_data_i;
  end

  // Configuration registers; core comes out of reset frozen
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cfg_freeze_r     <= 1'b1;
      cfg_core_id_r    <= '0;
      cfg_cce_mode_r   <= 1'b0;
      cfg_cache_mode_r <= 1'b0;
    end else if (reg_wr) begin
      case (off)
        cfg_reg_freeze_gp:     cfg_freeze_r     <= cmd.data[0];
        cfg_reg_core_id_gp:    cfg_core_id_r    <= cmd.data[core_id_width_p-1:0];
        cfg_reg_cce_mode_gp:   cfg_cce_mode_r   <= cmd.data[0];
        cfg_reg_cache_mode_gp: cfg_cache_mode_r <= cmd.data[0];
        default: ;
      endcase
    end
  end

  // Responder FSM with registered response message
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= e_ready;
      resp_r  <= '0;
    end else begin
      case (state_r)
        e_ready: begin
          if (accept) begin
            resp_r.header <= cmd.header;
            resp_r.data   <= (is_uc_rd && reg_hit) ? reg_rdata : '0;
            state_r       <= (is_uc_rd && ram_hit) ? e_ram_read : e_resp;
          end
        end
        e_ram_read: begin
          resp_r.data <= ram_rdata_ext;
          state_r     <= e_resp;
        end
        e_resp: begin
          if (io_resp_ready_i) state_r <= e_ready;
        end
        default: state_r <= e_ready;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cfg_io_responder.sv
// Self-checking bench for bp_cfg_io_responder: scoreboard of expected
// responses, reference model of config registers and instruction RAM.
module tb_bp_cfg_io_responder;
  import bp_cfg_io_pkg::*;

  localparam int els_lp = num_cce_instr_ram_els_p;
  localparam int iw_lp  = cce_inst_width_gp;
  localparam int aw_lp  = $clog2(els_lp);
  localparam int mw_lp  = $bits(bp_cce_io_msg_s);
  localparam int cw_lp  = core_id_width(e_bp_default_cfg);

  typedef struct {
    bp_cce_io_msg_s msg;
    int             acc_cyc;
    int             lat;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b0;
  logic [mw_lp-1:0]  io_cmd_i = '0;
  logic              io_cmd_v_i = 1'b0;
  logic              io_cmd_yumi_o;
  logic [mw_lp-1:0]  io_resp_o;
  logic              io_resp_v_o;
  logic              io_resp_ready_i = 1'b1;
  logic              cfg_freeze_o;
  logic [cw_lp-1:0]  cfg_core_id_o;
  logic              cfg_cce_mode_o;
  logic              cfg_cache_mode_o;
  logic              inst_ram_w_v_o;
  logic              inst_ram_r_v_o;
  logic [aw_lp-1:0]  inst_ram_addr_o;
  logic [iw_lp-1:0]  inst_ram_data_o;
  logic [iw_lp-1:0]  inst_ram_data_i = '0;

  bp_cce_io_msg_s    resp_view;
  assign resp_view = io_resp_o;

  bp_cfg_io_responder dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .io_cmd_i         (io_cmd_i),
    .io_cmd_v_i       (io_cmd_v_i),
    .io_cmd_yumi_o    (io_cmd_yumi_o),
    .io_resp_o        (io_resp_o),
    .io_resp_v_o      (io_resp_v_o),
    .io_resp_ready_i  (io_resp_ready_i),
    .cfg_freeze_o     (cfg_freeze_o),
    .cfg_core_id_o    (cfg_core_id_o),
    .cfg_cce_mode_o   (cfg_cce_mode_o),
    .cfg_cache_mode_o (cfg_cache_mode_o),
    .inst_ram_w_v_o   (inst_ram_w_v_o),
    .inst_ram_r_v_o   (inst_ram_r_v_o),
    .inst_ram_addr_o  (inst_ram_addr_o),
    .inst_ram_data_o  (inst_ram_data_o),
    .inst_ram_data_i  (inst_ram_data_i)
  );

  always #5 clk_i = ~clk_i;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  logic prev_v = 1'b0;
  exp_t sb_q[$];

  logic             mdl_freeze = 1'b1;
  logic [cw_lp-1:0] mdl_core_id = '0;
  logic             mdl_cce_mode = 1'b0;
  logic             mdl_cache_mode = 1'b0;
  logic [iw_lp-1:0] mdl_ram [els_lp];
  logic [iw_lp-1:0] env_ram [els_lp];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_cfg(input string tag);
    check({tag, "_freeze"},  cfg_freeze_o,     mdl_freeze);
    check({tag, "_core_id"}, cfg_core_id_o,    mdl_core_id);
    check({tag, "_cce"},     cfg_cce_mode_o,   mdl_cce_mode);
    check({tag, "_cache"},   cfg_cache_mode_o, mdl_cache_mode);
  endtask

  // Instruction RAM environment: one-cycle read latency
  always @(posedge clk_i) begin
    if (inst_ram_w_v_o) env_ram[inst_ram_addr_o] <= inst_ram_data_o;
    if (inst_ram_r_v_o) inst_ram_data_i <= env_ram[inst_ram_addr_o];
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  // Response monitor: pops the scoreboard on each completed handshake
  always @(negedge clk_i) begin
    if (!reset_i) begin
      prev_v = 1'b0;
    end else begin
      if (io_resp_v_o && !prev_v) first_cyc = cyc;
      prev_v = io_resp_v_o;
      if ((inst_ram_w_v_o || inst_ram_r_v_o) && !io_cmd_yumi_o)
        check("stray_strobe", 1'b1, 1'b0);
      if (io_resp_v_o && io_resp_ready_i) begin
        if (sb_q.size() == 0) begin
          check("spurious_resp", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("resp_msg", io_resp_o, e.msg);
          check("resp_latency", first_cyc - e.acc_cyc, e.lat);
        end
      end
    end
  end

  // Drive one command (called just after a rising edge); returns just after
  // the acceptance edge.
  task automatic issue(input bp_cce_mem_msg_type_e mt, input logic [15:0] off,
                       input logic [63:0] data);
    bp_cce_io_msg_s m;
    exp_t           e;
    logic [11:0]    idx;
    logic           ram_ok;
    logic [63:0]    rd;
    bit             acc;
    m.header.msg_type = mt;
    m.header.addr     = {24'h5A_0001, off};
    m.header.size     = 3'd3;
    m.data            = data;
    idx    = off[14:3];
    ram_ok = off[15] && (off[2:0] == 3'b000) && (int'(idx) < els_lp);
    rd     = '0;
    case (off)
      16'h0000: rd[0] = mdl_freeze;
      16'h0008: rd[cw_lp-1:0] = mdl_core_id;
      16'h0010: rd[0] = mdl_cce_mode;
      16'h0018: rd[0] = mdl_cache_mode;
      default:  rd = '0;
    endcase
    if (ram_ok) begin
      rd = '0;
      rd[iw_lp-1:0] = mdl_ram[idx];
    end
    io_cmd_i   = m;
    io_cmd_v_i = 1'b1;
    acc = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_i);
      if (io_cmd_yumi_o) begin
        acc = 1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    if (!acc) begin
      check("accept_timeout", 1'b0, 1'b1);
      io_cmd_v_i = 1'b0;
      return;
    end
    check("w_strobe", inst_ram_w_v_o, (mt == e_cce_mem_uc_wr) && ram_ok);
    check("r_strobe", inst_ram_r_v_o, (mt == e_cce_mem_uc_rd) && ram_ok);
    if (ram_ok && (mt == e_cce_mem_uc_wr || mt == e_cce_mem_uc_rd))
      check("ram_addr", inst_ram_addr_o, idx[aw_lp-1:0]);
    if (ram_ok && mt == e_cce_mem_uc_wr)
      check("ram_wdata", inst_ram_data_o, data[iw_lp-1:0]);
    e.msg.header = m.header;
    e.msg.data   = (mt == e_cce_mem_uc_rd) ? rd : 64'h0;
    e.acc_cyc    = cyc;
    e.lat        = (mt == e_cce_mem_uc_rd && ram_ok) ? 2 : 1;
    sb_q.push_back(e);
    if (mt == e_cce_mem_uc_wr) begin
      if (ram_ok) mdl_ram[idx] = data[iw_lp-1:0];
      case (off)
        16'h0000: mdl_freeze     = data[0];
        16'h0008: mdl_core_id    = data[cw_lp-1:0];
        16'h0010: mdl_cce_mode   = data[0];
        16'h0018: mdl_cache_mode = data[0];
        default: ;
      endcase
    end
    @(posedge clk_i);
    #1;
    io_cmd_v_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 100; n++) begin
      if (sb_q.size() == 0 && !io_resp_v_o) begin
        done = 1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    if (!done) begin
      check("idle_timeout", 1'b0, 1'b1);
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] ridx;
    logic [63:0] rdat;

    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    @(negedge clk_i);
    check_cfg("rst");
    check("rst_resp_v", io_resp_v_o, 1'b0);
    check("rst_yumi", io_cmd_yumi_o, 1'b0);
    check("rst_strobes", {inst_ram_w_v_o, inst_ram_r_v_o}, 2'b00);
    check("rst_resp_msg", io_resp_o, 0);
    @(posedge clk_i);
    #1;

    // Response held while consumer stalls; new command not consumed
    io_resp_ready_i = 1'b0;
    issue(e_cce_mem_uc_rd, 16'h0000, 64'h0);
    io_cmd_i   = '1;
    io_cmd_v_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("hold_valid", io_resp_v_o, 1'b1);
      check("hold_data", resp_view.data, 64'h1);
      if (sb_q.size() > 0) check("hold_msg", io_resp_o, sb_q[0].msg);
      check("hold_no_yumi", io_cmd_yumi_o, 1'b0);
      @(posedge clk_i);
      #1;
    end
    io_cmd_v_i = 1'b0;
    io_resp_ready_i = 1'b1;
    wait_idle();

    // Register writes and read-back
    issue(e_cce_mem_uc_wr, 16'h0008, 64'h3);
    @(negedge clk_i);
    check("core_id_n1", cfg_core_id_o, 4'h3);
    @(posedge clk_i);
    #1;
    wait_idle();
    issue(e_cce_mem_uc_wr, 16'h0000, 64'h2);
    issue(e_cce_mem_uc_wr, 16'h0010, 64'h1);
    issue(e_cce_mem_uc_wr, 16'h0018, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(e_cce_mem_uc_wr, 16'h0008, 64'h0000_0000_0000_FFF5);
    wait_idle();
    check_cfg("wr");
    issue(e_cce_mem_uc_rd, 16'h0000, 64'h0);
    issue(e_cce_mem_uc_rd, 16'h0008, 64'h0);
    issue(e_cce_mem_uc_rd, 16'h0010, 64'h0);
    issue(e_cce_mem_uc_rd, 16'h0018, 64'h0);
    wait_idle();

    // Instruction RAM write then read
    issue(e_cce_mem_uc_wr, 16'h8010, 64'hABCD);
    issue(e_cce_mem_uc_rd, 16'h8010, 64'h0);
    issue(e_cce_mem_uc_wr, 16'h87F8, 64'hFFFF_1234_5678_9ABC);
    issue(e_cce_mem_uc_rd, 16'h87F8, 64'h0);
    for (int i = 0; i < 6; i++) begin
      ridx = 12'($urandom_range(0, els_lp - 1));
      rdat = {$urandom, $urandom};
      issue(e_cce_mem_uc_wr, {1'b1, ridx[11:0], 3'b000}, rdat);
      issue(e_cce_mem_uc_rd, {1'b1, ridx[11:0], 3'b000}, 64'h0);
    end
    wait_idle();

    // Unmapped, out-of-range and non-uncached commands: no side effects
    issue(e_cce_mem_uc_wr, 16'h0100, 64'hFF);
    issue(e_cce_mem_uc_rd, 16'h8000 + 16'(8 * els_lp), 64'h0);
    issue(e_cce_mem_uc_wr, 16'h8000 + 16'(8 * els_lp), 64'h77);
    issue(e_cce_mem_uc_rd, 16'h0004, 64'h0);
    issue(e_cce_mem_uc_rd, 16'h8012, 64'h0);
    issue(e_cce_mem_wr, 16'h0008, 64'h7);
    issue(e_cce_mem_rd, 16'h0000, 64'h0);
    issue(e_cce_mem_pre, 16'h8010, 64'h0);
    wait_idle();
    check_cfg("unmapped");
    issue(e_cce_mem_uc_rd, 16'h8010, 64'h0);
    wait_idle();

    // Reset while waiting on RAM read data
    issue(e_cce_mem_uc_rd, 16'h8010, 64'h0);
    reset_i = 1'b0;
    #1;
    sb_q.delete();
    mdl_freeze = 1'b1;
    mdl_core_id = '0;
    mdl_cce_mode = 1'b0;
    mdl_cache_mode = 1'b0;
    io_cmd_v_i = 1'b1;
    #1;
    check("midrst_resp_v", io_resp_v_o, 1'b0);
    check("midrst_yumi", io_cmd_yumi_o, 1'b0);
    check("midrst_strobes", {inst_ram_w_v_o, inst_ram_r_v_o}, 2'b00);
    check("midrst_resp_msg", io_resp_o, 0);
    check_cfg("midrst");
    io_cmd_v_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("postrst_no_resp", io_resp_v_o, 1'b0);
    end
    check_cfg("postrst");
    @(posedge clk_i);
    #1;
    issue(e_cce_mem_uc_rd, 16'h0000, 64'h0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
